alu_issue_queue: RTL and testbench

//   Reservation station and issue scheduler for the single-cycle ALU functional unit (alu_fu).
//   - Holds dispatched ALU ops until their source physical registers are ready.
//   - Tracks readiness by snooping the CDB.
//   - Issues the oldest ready op per cycle through a valid/ready handshake.
//   - Sits between rename/dispatch and alu_fu; alu_fu reads the PRF itself using the issued tags.

---
 rtl/alu_issue_queue.sv | 136 +++++++++++++
 tb/tb_alu_issue_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds dispatched ops until both sources are ready,
// snoops the CDB for wakeups and issues the oldest ready op each cycle.

localparam int PREG_W    = 6;
localparam int ROB_TAG_W = 5;

typedef struct packed {
    logic [PREG_W-1:0]    rs1_tag;
    logic [PREG_W-1:0]    rs2_tag;
    logic [PREG_W-1:0]    rd_tag;
    logic                 rd_used;
    logic [3:0]           alu_op;
    logic [31:0]          imm;
    logic                 imm_used;
    logic [ROB_TAG_W-1:0] rob_tag;
} issue_pkt_t;

module alu_issue_queue #(
    parameter int DEPTH = 8,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              disp_valid_i,
    output logic              disp_ready_o,
    input  issue_pkt_t        disp_pkt_i,
    input  logic              disp_rs1_rdy_i,
    input  logic              disp_rs2_rdy_i,
    input  logic              cdb_valid_i,
    input  logic [PREG_W-1:0] cdb_tag_i,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output issue_pkt_t        issue_pkt_o,
    output logic [OCC_W-1:0]  occupancy_o
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] rs1_rdy_q, rs1_rdy_d;
    logic [DEPTH-1:0] rs2_rdy_q, rs2_rdy_d;
    // older_q[i][j] = 1 when entry i arrived before entry j
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    issue_pkt_t       pkt_q   [DEPTH];

    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] sel_oh;
    logic [DEPTH-1:0] alloc_oh;
    logic             alloc_found;
    logic [OCC_W-1:0] occ;
    logic             disp_fire;
    logic             issue_fire;
    logic             disp_rs1_wake;
    logic             disp_rs2_wake;

    // Occupancy, free-slot search and oldest-ready select, all from registered state.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        occ         = '0;
        alloc_oh    = '0;
        alloc_found = 1'b0;
        cand        = valid_q & rs1_rdy_q & rs2_rdy_q;
        sel_oh      = cand;
        issue_pkt_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + OCC_W'(valid_q[i]);
            if (!valid_q[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && cand[j] && older_q[j][i]) sel_oh[i] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) issue_pkt_o = pkt_q[i];
        end
    end

    assign occupancy_o   = occ;
    assign disp_ready_o  = (occ != OCC_W'(DEPTH));
    assign issue_valid_o = |cand;
    assign disp_fire     = disp_valid_i && disp_ready_o;
    assign issue_fire    = issue_valid_o && issue_ready_i;
    assign disp_rs1_wake = cdb_valid_i && (cdb_tag_i == disp_pkt_i.rs1_tag);
    assign disp_rs2_wake = cdb_valid_i && (cdb_tag_i == disp_pkt_i.rs2_tag);

    always_comb begin
        valid_d   = valid_q;
        rs1_rdy_d = rs1_rdy_q;
        rs2_rdy_d = rs2_rdy_q;
        older_d   = older_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (cdb_valid_i && valid_q[i]) begin
                if (pkt_q[i].rs1_tag == cdb_tag_i) rs1_rdy_d[i] = 1'b1;
                if (pkt_q[i].rs2_tag == cdb_tag_i) rs2_rdy_d[i] = 1'b1;
            end
        end
        if (issue_fire) valid_d = valid_d & ~sel_oh;
        if (disp_fire) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    valid_d[i]   = 1'b1;
                    rs1_rdy_d[i] = disp_rs1_rdy_i || disp_rs1_wake;
                    rs2_rdy_d[i] = disp_pkt_i.imm_used || disp_rs2_rdy_i || disp_rs2_wake;
                    older_d[i]   = '0;
                    for (int j = 0; j < DEPTH; j++) older_d[j][i] = valid_q[j];
                end
            end
        end
        if (flush_i) valid_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            older_q   <= older_d;
        end
    end

    // NOTE: the payload array has no reset; it is only ever read behind a valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && alloc_oh[i]) pkt_q[i] <= disp_pkt_i;
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue; a negedge monitor checks every issue
// handshake against a scoreboard of expected packets in expected order.

module tb_alu_issue_queue;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush_i;
    logic              disp_valid_i;
    logic              disp_ready_o;
    issue_pkt_t        disp_pkt_i;
    logic              disp_rs1_rdy_i;
    logic              disp_rs2_rdy_i;
    logic              cdb_valid_i;
    logic [PREG_W-1:0] cdb_tag_i;
    logic              issue_valid_o;
    logic              issue_ready_i;
    issue_pkt_t        issue_pkt_o;
    logic [3:0]        occupancy_o;

    int n_checks = 0;
    int n_fail   = 0;
    issue_pkt_t exp_q[$];

    alu_issue_queue #(.DEPTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush_i        (flush_i),
        .disp_valid_i   (disp_valid_i),
        .disp_ready_o   (disp_ready_o),
        .disp_pkt_i     (disp_pkt_i),
        .disp_rs1_rdy_i (disp_rs1_rdy_i),
        .disp_rs2_rdy_i (disp_rs2_rdy_i),
        .cdb_valid_i    (cdb_valid_i),
        .cdb_tag_i      (cdb_tag_i),
        .issue_valid_o  (issue_valid_o),
        .issue_ready_i  (issue_ready_i),
        .issue_pkt_o    (issue_pkt_o),
        .occupancy_o    (occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic issue_pkt_t mk_pkt(input int rob, input int rs1, input int rs2, input logic imm_used);
        issue_pkt_t p;
        p.rs1_tag  = PREG_W'(rs1);
        p.rs2_tag  = PREG_W'(rs2);
        p.rd_tag   = PREG_W'(rob + 20);
        p.rd_used  = 1'b1;
        p.alu_op   = 4'(rob);
        p.imm      = 32'hA000_0000 + 32'(rob);
        p.imm_used = imm_used;
        p.rob_tag  = ROB_TAG_W'(rob);
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input issue_pkt_t p, input logic r1, input logic r2);
        disp_valid_i   = 1'b1;
        disp_pkt_i     = p;
        disp_rs1_rdy_i = r1;
        disp_rs2_rdy_i = r2;
        step();
        disp_valid_i   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 20) begin
            step();
            cnt++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every handshake must match the next expected packet.
    initial begin
        issue_pkt_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !flush_i && issue_valid_o && issue_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got rob %0d expected none", issue_pkt_o.rob_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_pkt", 64'(issue_pkt_o), 64'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; disp_valid_i = 1'b0; disp_pkt_i = '0;
        disp_rs1_rdy_i = 1'b0; disp_rs2_rdy_i = 1'b0; cdb_valid_i = 1'b0;
        cdb_tag_i = '0; issue_ready_i = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // 1: reset values, then a ready op issues one cycle after dispatch
        check("rst_issue_valid", 64'(issue_valid_o), 64'd0);
        check("rst_issue_pkt", 64'(issue_pkt_o), 64'd0);
        check("rst_disp_ready", 64'(disp_ready_o), 64'd1);
        check("rst_occ", 64'(occupancy_o), 64'd0);
        dispatch(mk_pkt(1, 1, 2, 1'b0), 1'b1, 1'b1);
        check("t1_issue_valid", 64'(issue_valid_o), 64'd1);
        check("t1_rob", 64'(issue_pkt_o.rob_tag), 64'd1);
        check("t1_occ", 64'(occupancy_o), 64'd1);
        exp_q.push_back(mk_pkt(1, 1, 2, 1'b0));
        issue_ready_i = 1'b1;
        step();
        issue_ready_i = 1'b0;
        check("t1_occ_after", 64'(occupancy_o), 64'd0);
        check("t1_drained", 64'(exp_q.size()), 64'd0);

        // 2: younger ready op bypasses an older waiting one; CDB wakes the older
        issue_ready_i = 1'b1;
        exp_q.push_back(mk_pkt(3, 7, 8, 1'b0));
        exp_q.push_back(mk_pkt(2, 5, 6, 1'b0));
        dispatch(mk_pkt(2, 5, 6, 1'b0), 1'b0, 1'b1);
        dispatch(mk_pkt(3, 7, 8, 1'b0), 1'b1, 1'b1);
        step();
        check("t2_waiting", 64'(issue_valid_o), 64'd0);
        check("t2_occ_waiting", 64'(occupancy_o), 64'd1);
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd5;
        step();
        cdb_valid_i = 1'b0;
        check("t2_woken", 64'(issue_valid_o), 64'd1);
        wait_drain("t2_drain");
        check("t2_occ_end", 64'(occupancy_o), 64'd0);

        // 3: fill, refuse extra, wake all, drain in age order (full-queue issue still refuses dispatch)
        issue_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) dispatch(mk_pkt(8 + k, 10, 11, 1'b0), 1'b0, 1'b1);
        check("t3_full_ready", 64'(disp_ready_o), 64'd0);
        check("t3_full_occ", 64'(occupancy_o), 64'd8);
        dispatch(mk_pkt(31, 1, 1, 1'b0), 1'b1, 1'b1);
        check("t3_extra_occ", 64'(occupancy_o), 64'd8);
        check("t3_none_ready", 64'(issue_valid_o), 64'd0);
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd10;
        step();
        cdb_valid_i = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(mk_pkt(8 + k, 10, 11, 1'b0));
        issue_ready_i = 1'b1;
        disp_valid_i = 1'b1; disp_pkt_i = mk_pkt(30, 1, 1, 1'b0);
        disp_rs1_rdy_i = 1'b1; disp_rs2_rdy_i = 1'b1;
        check("t3_full_issue_ready", 64'(disp_ready_o), 64'd0);
        step();
        disp_valid_i = 1'b0;
        repeat (7) step();
        check("t3_occ_end", 64'(occupancy_o), 64'd0);
        check("t3_drained", 64'(exp_q.size()), 64'd0);

        // 4: same-cycle CDB wakeup at dispatch; immediate op ignores rs2 readiness
        issue_ready_i = 1'b0;
        cdb_valid_i = 1'b1; cdb_tag_i = 6'd9;
        dispatch(mk_pkt(4, 3, 9, 1'b0), 1'b1, 1'b0);
        cdb_valid_i = 1'b0;
        check("t4_bypass_valid", 64'(issue_valid_o), 64'd1);
        check("t4_bypass_rob", 64'(issue_pkt_o.rob_tag), 64'd4);
        dispatch(mk_pkt(5, 3, 12, 1'b1), 1'b1, 1'b0);
        exp_q.push_back(mk_pkt(4, 3, 9, 1'b0));
        exp_q.push_back(mk_pkt(5, 3, 12, 1'b1));
        issue_ready_i = 1'b1;
        wait_drain("t4_drain");

        // 5: backpressure keeps the oldest packet stable
        issue_ready_i = 1'b0;
        dispatch(mk_pkt(6, 1, 2, 1'b0), 1'b1, 1'b1);
        dispatch(mk_pkt(7, 3, 4, 1'b0), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("t5_hold_valid", 64'(issue_valid_o), 64'd1);
            check("t5_hold_rob", 64'(issue_pkt_o.rob_tag), 64'd6);
            step();
        end
        exp_q.push_back(mk_pkt(6, 1, 2, 1'b0));
        exp_q.push_back(mk_pkt(7, 3, 4, 1'b0));
        issue_ready_i = 1'b1;
        step();
        check("t5_second_rob", 64'(issue_pkt_o.rob_tag), 64'd7);
        step();
        check("t5_empty", 64'(issue_valid_o), 64'd0);
        check("t5_drained", 64'(exp_q.size()), 64'd0);

        // 6: flush beats a same-cycle dispatch; async reset mid-run
        issue_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) dispatch(mk_pkt(16 + k, 1, 2, 1'b0), 1'b1, 1'b1);
        check("t6_occ5", 64'(occupancy_o), 64'd5);
        flush_i = 1'b1;
        dispatch(mk_pkt(21, 1, 2, 1'b0), 1'b1, 1'b1);
        flush_i = 1'b0;
        check("t6_flush_occ", 64'(occupancy_o), 64'd0);
        check("t6_flush_valid", 64'(issue_valid_o), 64'd0);
        step();
        check("t6_flush_stays", 64'(occupancy_o), 64'd0);
        dispatch(mk_pkt(22, 1, 2, 1'b0), 1'b1, 1'b1);
        dispatch(mk_pkt(23, 1, 2, 1'b0), 1'b1, 1'b1);
        check("t6_pre_rst_occ", 64'(occupancy_o), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_occ", 64'(occupancy_o), 64'd0);
        check("t6_rst_valid", 64'(issue_valid_o), 64'd0);
        check("t6_rst_pkt", 64'(issue_pkt_o), 64'd0);
        check("t6_rst_ready", 64'(disp_ready_o), 64'd1);
        step();
        rst_n = 1'b1;
        step();
        check("t6_post_rst_occ", 64'(occupancy_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
